decoder_scoreboard: RTL

DECODER_SCOREBOARD -- requirements
Module: decoder_scoreboard

---
 rtl/decoder_scoreboard_pkg.sv | 29 ++
 rtl/decoder_scoreboard_decoder_n.sv | 22 ++
 rtl/decoder_scoreboard.sv | 112 +++++++++++
 3 files changed

// File: rtl/decoder_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : decoder_scoreboard_pkg
//  Brief   : Shared types and helpers for the register-pending scoreboard.
//  Revision: 1.0 - initial release
// ============================================================================
package decoder_scoreboard_pkg;

    // Net effect of one cycle on the pending-entry counter
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // An entry appearing and another disappearing in the same cycle cancel out
    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        cnt_op_e op;
        op = CNT_HOLD;
        if (inc && !dec) begin
            op = CNT_INC;
        end else if (dec && !inc) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scoreboard_decoder_n.sv
`default_nettype none
// ============================================================================
//  Module  : decoder_n
//  Brief   : Enable-gated binary to one-hot decoder, N = 2**ADDR_W outputs.
//  Revision: 1.0 - initial release
// ============================================================================
module decoder_n #(
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0]      in,
    input  logic                   en,
    output logic [(2**ADDR_W)-1:0] out
);

    // Exactly one bit high when enabled, all zero otherwise
    always_comb begin
        out     = '0;
        out[in] = en;
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : decoder_scoreboard
//  Brief   : Register scoreboard tracking outstanding writes, raising a RAW
//            hazard for decode and counting pending entries. Writebacks in
//            the current cycle bypass into the hazard check.
//  Revision: 1.0 - initial release
// ============================================================================
module decoder_scoreboard #(
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    input  logic [ADDR_W-1:0]      src_a_addr,
    input  logic [ADDR_W-1:0]      src_b_addr,
    input  logic                   src_a_use,
    input  logic                   src_b_use,
    output logic [(2**ADDR_W)-1:0] dec_out,
    output logic [(2**ADDR_W)-1:0] pending,
    output logic                   hazard,
    output logic [ADDR_W:0]        busy_cnt,
    output logic                   err
);

    import decoder_scoreboard_pkg::*;

    localparam int N = 2**ADDR_W;

    // Entry 0 is masked out of every state update when it is a constant register
    localparam logic [N-1:0] c_zero_mask = {{(N-1){1'b0}}, ZERO_REG};

    logic [N-1:0]    pending_q,  pending_d;
    logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;
    logic            err_q,      err_d;

    logic [N-1:0]    w_clr_oh;
    logic [N-1:0]    w_pend_eff;
    logic [N-1:0]    w_set_eff;
    logic [N-1:0]    w_clr_eff;
    logic            w_set_acc;
    logic            w_inc;
    logic            w_dec;
    logic            w_err;

    decoder_n #(.ADDR_W(ADDR_W)) u_dec_clr (
        .in  (clr_addr),
        .en  (clr_en),
        .out (w_clr_oh)
    );

    decoder_n #(.ADDR_W(ADDR_W)) u_dec_set (
        .in  (set_addr),
        .en  (w_set_acc),
        .out (dec_out)
    );

    // Hazard check with same-cycle writeback bypass; a stalled issue is dropped
    always_comb begin
        w_pend_eff = pending_q & ~w_clr_oh;
        hazard     = (src_a_use & w_pend_eff[src_a_addr])
                   | (src_b_use & w_pend_eff[src_b_addr]);
        w_set_acc  = set_en & ~hazard;
    end

    // Next pending vector, counter delta and protocol-error detection
    always_comb begin
        w_set_eff = dec_out  & ~c_zero_mask;
        w_clr_eff = w_clr_oh & ~c_zero_mask;

        // New writer wins over a writeback to the same register
        pending_d = (pending_q & ~w_clr_eff) | w_set_eff;

        // Count only transitions of pending; a set+clear of a pending entry nets zero
        w_inc = |(w_set_eff & ~pending_q);
        w_dec = |(w_clr_eff &  pending_q & ~w_set_eff);

        w_err = (|(w_clr_eff & ~pending_q))
              | (|(w_set_eff &  pending_q & ~w_clr_eff));

        unique case (cnt_op(w_inc, w_dec))
            CNT_INC: busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            CNT_DEC: busy_cnt_d = busy_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
            default: busy_cnt_d = busy_cnt_q;
        endcase

        err_d = err_q | w_err;
    end

    // State registers; reset discards any same-cycle set or clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pending  = pending_q;
    assign busy_cnt = busy_cnt_q;
    assign err      = err_q;

endmodule
`default_nettype wire
